// File: rtl/memoria_dados_hs.sv
// Handshaked single-port data memory with programmable access latency and an
// address range check. Defining MEMDADOS_CLEAR_EN adds a zero-fill after reset.
//
// state | meaning
// CLEAR | writing zero to one word per cycle after reset (MEMDADOS_CLEAR_EN only)
// IDLE  | ready to accept a request
// WAIT  | latency countdown; access executes when the counter reaches 0
// RESP  | response presented until the consumer accepts it

module memoria_dados_hs #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT_INIT = 4'(LATENCY);
    localparam logic [31:0] DEPTH_U  = 32'(DEPTH);

    typedef enum logic [1:0] {
`ifdef MEMDADOS_CLEAR_EN
        S_CLEAR = 2'd0,
`endif
        S_IDLE  = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

`ifdef MEMDADOS_CLEAR_EN
    localparam state_t           RST_STATE = S_CLEAR;
    localparam logic [IDX_W-1:0] CLR_LAST  = IDX_W'(DEPTH - 1);
    logic [IDX_W-1:0] clr_addr;
`else
    localparam state_t RST_STATE = S_IDLE;
`endif

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              addr_oob;
    logic              exec;
    logic [IDX_W-1:0]  idx;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign idx      = addr_q[IDX_W-1:0];
    assign addr_oob = (32'(addr_q) >= DEPTH_U);
    assign exec     = (state == S_WAIT) && (cnt == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_STATE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        busy       = 1'b1;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        case (state)
`ifdef MEMDADOS_CLEAR_EN
            S_CLEAR: begin
                if (clr_addr == CLR_LAST) state_nx = S_IDLE;
            end
`endif
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_nx = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = rdata_q;
                if (resp_ready) state_nx = S_IDLE;
            end
            default: state_nx = RST_STATE;
        endcase
    end

    // Out-of-range writes never reach the array.
    always_comb begin
        mem_we    = exec && we_q && !addr_oob;
        mem_waddr = idx;
        mem_wdata = wdata_q;
`ifdef MEMDADOS_CLEAR_EN
        if (state == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = '0;
        end
`endif
    end

    // Array has no reset so its contents survive rst; rst still blocks a commit.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef MEMDADOS_CLEAR_EN
            clr_addr <= '0;
`endif
        end else begin
            case (state)
`ifdef MEMDADOS_CLEAR_EN
                S_CLEAR: clr_addr <= clr_addr + IDX_W'(1);
`endif
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt     <= LAT_INIT;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        err_q   <= addr_oob;
                        rdata_q <= (we_q || addr_oob) ? '0 : mem[idx];
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memoria_dados_hs.sv
// Bench for memoria_dados_hs: three instances (defaults/LATENCY=2, DEPTH=200, DEPTH=16/LATENCY=0),
// table-driven accesses checked through a response scoreboard, plus reset and clear sequences.

module tb_memoria_dados_hs;

    typedef struct packed {
        logic [1:0] inst;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       err;
        logic [3:0] hold;
    } vec_t;

    typedef struct packed {
        logic [1:0] inst;
        logic [7:0] rdata;
        logic       err;
    } sb_t;

    localparam int NV = 19;
`ifdef MEMDADOS_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst        [3];
    logic       req_valid  [3];
    logic       req_ready  [3];
    logic       req_we     [3];
    logic [7:0] req_addr   [3];
    logic [7:0] req_wdata  [3];
    logic       resp_valid [3];
    logic       resp_ready [3];
    logic [7:0] resp_rdata [3];
    logic       resp_err   [3];
    logic       busy       [3];

    int   n_cmp = 0;
    int   n_bad = 0;
    sb_t  sb[$];
    vec_t vecs [NV];

    always #5 clk = ~clk;

    memoria_dados_hs #(.LATENCY(2)) u_def (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0]), .busy(busy[0]));

    memoria_dados_hs #(.DEPTH(200), .LATENCY(2)) u_d200 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1]), .busy(busy[1]));

    memoria_dados_hs #(.DEPTH(16), .LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]),
        .resp_err(resp_err[2]), .busy(busy[2]));

    function automatic int lat_of(input int i);
        return (i == 2) ? 0 : 2;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout, expected DUT event at %0t", nm, $time);
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (busy[i] && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy[i]) note_fail("wait_idle");
    endtask

    // Scoreboard consumer: every response handshake pops one expected entry.
    always @(negedge clk) begin : mon
        sb_t e;
        for (int i = 0; i < 3; i++) begin
            if (resp_valid[i] === 1'b1 && resp_ready[i] === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got response on inst %0d, expected none", i);
                end else begin
                    e = sb.pop_front();
                    chk("resp_inst", i, e.inst);
                    chk("resp_rdata", resp_rdata[i], e.rdata);
                    chk("resp_err", resp_err[i], e.err);
                end
            end
        end
    end

    task automatic do_access(input int i, input logic we, input logic [7:0] a, input logic [7:0] wd,
                             input logic [7:0] er, input logic ee, input int hold);
        int n;
        @(negedge clk);
        resp_ready[i] = (hold == 0);
        req_valid[i]  = 1'b1;
        req_we[i]     = we;
        req_addr[i]   = a;
        req_wdata[i]  = wd;
        n = 0;
        while (!req_ready[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[i]) begin
            req_valid[i] = 1'b0;
            note_fail("accept");
            return;
        end
        sb.push_back('{inst: 2'(i), rdata: er, err: ee});
        @(posedge clk); #1;
        // Scramble inputs after acceptance; the in-flight access must not see this.
        req_valid[i] = 1'b0;
        req_we[i]    = ~we;
        req_addr[i]  = ~a;
        req_wdata[i] = ~wd;
        chk("wait_valid", resp_valid[i], 0);
        chk("wait_rdata", resp_rdata[i], 0);
        n = 0;
        while (!resp_valid[i] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!resp_valid[i]) begin
            void'(sb.pop_back());
            note_fail("resp_timeout");
            return;
        end
        chk("latency", n, lat_of(i) + 1);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", resp_valid[i], 1);
            chk("hold_rdata", resp_rdata[i], er);
            chk("hold_err", resp_err[i], ee);
            chk("hold_req_ready", req_ready[i], 0);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            resp_ready[i] = 1'b1;
        end
        @(posedge clk); #1;
        chk("idle_ready", req_ready[i], 1);
        chk("idle_busy", busy[i], 0);
        chk("idle_valid", resp_valid[i], 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 3; i++) begin
            rst[i]        = 1'b1;
            req_valid[i]  = 1'b0;
            req_we[i]     = 1'b0;
            req_addr[i]   = 8'h00;
            req_wdata[i]  = 8'h00;
            resp_ready[i] = 1'b1;
        end

        //          inst  we    addr   wdata  rdata  err   hold
        vecs[0]  = '{2'd0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0, 4'd0};
        vecs[1]  = '{2'd0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 4'd0};
        vecs[2]  = '{2'd0, 1'b1, 8'hFF, 8'h5A, 8'h00, 1'b0, 4'd0};
        vecs[3]  = '{2'd0, 1'b0, 8'hFF, 8'h00, 8'h5A, 1'b0, 4'd0};
        vecs[4]  = '{2'd0, 1'b1, 8'h20, 8'hC3, 8'h00, 1'b0, 4'd0};
        vecs[5]  = '{2'd0, 1'b0, 8'h20, 8'h00, 8'hC3, 1'b0, 4'd5};
        vecs[6]  = '{2'd0, 1'b1, 8'h05, 8'h11, 8'h00, 1'b0, 4'd0};
        vecs[7]  = '{2'd1, 1'b1, 8'h48, 8'h33, 8'h00, 1'b0, 4'd0};
        vecs[8]  = '{2'd1, 1'b1, 8'hC8, 8'h77, 8'h00, 1'b1, 4'd0};
        vecs[9]  = '{2'd1, 1'b0, 8'hC8, 8'h00, 8'h00, 1'b1, 4'd0};
        vecs[10] = '{2'd1, 1'b0, 8'h48, 8'h00, 8'h33, 1'b0, 4'd0};
        vecs[11] = '{2'd1, 1'b1, 8'hC7, 8'h11, 8'h00, 1'b0, 4'd0};
        vecs[12] = '{2'd1, 1'b0, 8'hC7, 8'h00, 8'h11, 1'b0, 4'd0};
        vecs[13] = '{2'd2, 1'b1, 8'h03, 8'h9C, 8'h00, 1'b0, 4'd0};
        vecs[14] = '{2'd2, 1'b0, 8'h03, 8'h00, 8'h9C, 1'b0, 4'd0};
        vecs[15] = '{2'd2, 1'b1, 8'h10, 8'hEE, 8'h00, 1'b1, 4'd0};
        vecs[16] = '{2'd2, 1'b1, 8'h0F, 8'hE1, 8'h00, 1'b0, 4'd0};
        vecs[17] = '{2'd2, 1'b0, 8'h0F, 8'h00, 8'hE1, 1'b0, 4'd0};
        vecs[18] = '{2'd2, 1'b0, 8'h10, 8'h00, 8'h00, 1'b1, 4'd0};

        #2;
        for (int i = 0; i < 3; i++) begin
            chk("rst_valid", resp_valid[i], 0);
            chk("rst_err", resp_err[i], 0);
            chk("rst_rdata", resp_rdata[i], 0);
            chk("rst_busy", busy[i], CLR);
            chk("rst_ready", req_ready[i], !CLR);
        end
        #15;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        for (int i = 0; i < 3; i++) wait_idle(i);

        for (int v = 0; v < NV; v++)
            do_access(vecs[v].inst, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                      vecs[v].rdata, vecs[v].err, vecs[v].hold);

        // Reset during WAIT of a write: the write must not land.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 8'h05;
        req_wdata[0] = 8'h3C;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        chk("rw_busy_wait", busy[0], 1);
        #2 rst[0] = 1'b1;
        #1;
        chk("rw_valid", resp_valid[0], 0);
        chk("rw_rdata", resp_rdata[0], 0);
        chk("rw_err", resp_err[0], 0);
        chk("rw_ready", req_ready[0], !CLR);
        repeat (3) @(posedge clk);
        #1 rst[0] = 1'b0;
        wait_idle(0);
        do_access(0, 1'b0, 8'h05, 8'h00, CLR ? 8'h00 : 8'h11, 1'b0, 0);

        // Reset while a read response is being held.
        @(negedge clk);
        resp_ready[1] = 1'b0;
        req_valid[1]  = 1'b1;
        req_we[1]     = 1'b0;
        req_addr[1]   = 8'h48;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        n = 0;
        while (!resp_valid[1] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rr_valid_pre", resp_valid[1], 1);
        chk("rr_rdata_pre", resp_rdata[1], 8'h33);
        #2 rst[1] = 1'b1;
        #1;
        chk("rr_valid", resp_valid[1], 0);
        chk("rr_rdata", resp_rdata[1], 0);
        chk("rr_err", resp_err[1], 0);
        @(posedge clk); #1;
        rst[1]        = 1'b0;
        resp_ready[1] = 1'b1;
        wait_idle(1);

`ifdef MEMDADOS_CLEAR_EN
        // Clear sequence on DEPTH=16, interrupted once by a second reset.
        @(negedge clk) rst[2] = 1'b1;
        @(negedge clk) rst[2] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("clr_busy_mid", busy[2], 1);
        chk("clr_ready_mid", req_ready[2], 0);
        rst[2] = 1'b1;
        @(negedge clk) rst[2] = 1'b0;
        n = 0;
        while (busy[2] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("clr_edges", n, 16);
        for (int a = 0; a < 16; a++)
            do_access(2, 1'b0, 8'(a), 8'h00, 8'h00, 1'b0, 0);
`endif

        repeat (3) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
